rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. It accepts register writes from three producers (0 = ALU, 1 = load unit, 2 = mul/div unit), holds one pending write per producer, and grants one per cycle round-robin. It drives a registered write (`rf_wr`, `rf_a3`, `rf_wd`) into the register file's `RFWr`/`A3`/`WD` inputs, which the register file commits on the falling clock edge. It also publishes a pending-write mask for hazard detection in the issue stage.

## Interface
- `NSRC`, 3: number of write-back sources; fixed, not overridable.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in [2:0]: per-source write request.
- `req_ready` out [2:0]: per-source accept; combinational.
- `req_addr` in [14:0]: source i destination register at [5i+4:5i].
- `req_data` in [95:0]: source i write data at [32i+31:32i].
- `rf_wr` out 1: registered write enable to the register file.
- `rf_a3` out [4:0]: registered write address.
- `rf_wd` out [31:0]: registered write data.
- `pending` out [31:0]: bit r set while any slot or the output stage holds a write to r; bit 0 always 0.
- `byp_a1`, `byp_a2` in [4:0]: bypass lookup addresses (only with `RF_WB_BYPASS_EN`).
- `byp_hit1`, `byp_hit2` out 1: bypass hit (only with `RF_WB_BYPASS_EN`).
- `byp_d1`, `byp_d2` out [31:0]: bypass data (only with `RF_WB_BYPASS_EN`).

## Operation
- **Per-source slot:** valid, addr[4:0], data[31:0]. A request is accepted on a rising edge when `req_valid[i] & req_ready[i]`.
- **Ready:** `req_ready[i]` = `rst_n` & (slot i empty | slot i granted this cycle) & no address conflict.
- **Address conflict:**
  - `req_addr[i]` matches the occupied, not-granted-this-cycle slot of another source.
  - Or a lower-index source presents a valid request to the same address this cycle (lower index wins).
  - Preserves write order to any one register.
- **Address 0:** the request is accepted (ready follows the normal rule, minus conflict) but discarded. The slot is not loaded, `rf_wr` never fires, and `pending[0]` is never set.
- **Arbitration:**
  - Round-robin pointer `rr`, 0..2.
  - Grant goes to the first occupied slot scanning `rr`, `rr+1`, `rr+2` (mod 3).
  - On a grant to source g: `rr` <= (g+1) mod 3. With no grant, `rr` holds.
- **Output stage:** each edge, `rf_wr` <= grant_valid. When granted, `rf_a3`/`rf_wd` <= the granted slot's addr/data. When not granted, they hold their previous values.
- **Slot update:**
  - A granted slot clears.
  - If a request is accepted in the same cycle, it reloads with the new request; grant and accept may coincide.
- **`pending`:** OR of one-hot(addr) over occupied slots plus the output stage when `rf_wr` = 1.
- **Reset (`rst_n` = 0 at an edge):**
  - All slots empty, `rr` = 0, `rf_wr` = 0, `rf_a3` = 0, `rf_wd` = 0, so `pending` = 0.
  - Held writes are discarded, including mid-operation; no partial write is issued.

## Timing
- Uncontended latency is 2 rising edges:
  - Edge E0: request accepted.
  - Cycle E0→E1: slot granted.
  - Edge E1: `rf_wr` = 1 for cycle E1→E2.
  - Register file commits at the falling edge inside E1→E2.
- Throughput is one write per cycle aggregate. A single source streaming alone gets one accept per cycle, since ready stays high through grant-and-reload.
- Under full contention, each source is granted at least once every 3 cycles.
- `req_ready` depends combinationally on `req_valid`/`req_addr`. Sources must not make `req_valid` depend on `req_ready`.

## Configuration
- Macro: `RF_WB_BYPASS_EN`.
- **Defined:** the bypass ports exist. `byp_hitN` = (`byp_aN` != 0) & (match in any occupied slot | match in the output stage with `rf_wr` = 1). `byp_dN` takes slot data over output-stage data (the slot is newer). When there is no hit, `byp_dN` = 0. Purely combinational.
- **Undefined:** the bypass ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then source 1 writes r5 = 0x12345678 at E0 → `rf_wr` = 1, `rf_a3` = 5, `rf_wd` = 0x12345678 in cycle E1→E2; `pending` bit 5 high in cycles E0→E2 only.
- All three sources hold valid writes (r1, r2, r3) with `rr` = 0 → grants in order 0, 1, 2 on consecutive cycles; `rr` returns to 0.
- Sources 0 and 2 both request r7 in the same cycle → source 0 accepted, `req_ready[2]` = 0. Source 2 is accepted in the cycle source 0's slot is granted. Register file ends holding source 2's data.
- Source 0 requests r0 = 0xFFFFFFFF → accepted, `rf_wr` stays 0, `pending` = 0.
- Reset asserted with two slots occupied → next cycle `rf_wr` = 0, `pending` = 0, `req_ready` = 0 while `rst_n` = 0; no write is ever issued for the held entries.
- `RF_WB_BYPASS_EN`:
  - Slot 1 holds r9 = 0xA, output stage holds r9 = 0xB → `byp_a1` = 9 gives hit = 1, data = 0xA.
  - `byp_a1` = 0 gives hit = 0, data = 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the register file's single write port.
// Three producers (0 = ALU, 1 = load unit, 2 = mul/div) each own one pending-write
// slot. One slot per cycle is granted round-robin into a registered output stage
// that drives RFWr/A3/WD. Same-register writes are ordered by refusing a request
// while an older, still-held write to that register exists.
// Optional feature macro: RF_WB_BYPASS_EN adds two combinational bypass lookup ports.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [14:0] req_addr,
    input  logic [95:0] req_data,
    output logic        rf_wr,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
`ifdef RF_WB_BYPASS_EN
    input  logic [4:0]  byp_a1,
    input  logic [4:0]  byp_a2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_d1,
    output logic [31:0] byp_d2,
`endif
    output logic [31:0] pending
);

    localparam int NSRC = 3;

    logic [NSRC-1:0] slot_v;
    logic [4:0]      slot_a [NSRC];
    logic [31:0]     slot_d [NSRC];
    logic [1:0]      rr;

    logic [4:0]      req_a [NSRC];
    logic [31:0]     req_d [NSRC];

    logic [1:0]      scan [NSRC];
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic [4:0]      grant_a;
    logic [31:0]     grant_d;
    logic [NSRC-1:0] granted;
    logic [1:0]      rr_next;

    logic [NSRC-1:0] conflict;
    logic [NSRC-1:0] accept;

    // Unpack the flat request buses into per-source fields.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            req_a[i] = req_addr[5*i +: 5];
            req_d[i] = req_data[32*i +: 32];
        end
    end

    // Round-robin pick: first occupied slot scanning rr, rr+1, rr+2 (mod 3).
    always_comb begin
        case (rr)
            2'd1:    begin scan[0] = 2'd1; scan[1] = 2'd2; scan[2] = 2'd0; end
            2'd2:    begin scan[0] = 2'd2; scan[1] = 2'd0; scan[2] = 2'd1; end
            default: begin scan[0] = 2'd0; scan[1] = 2'd1; scan[2] = 2'd2; end
        endcase
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        grant_a     = 5'd0;
        grant_d     = 32'd0;
        for (int k = 0; k < NSRC; k++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (!grant_valid && scan[k] == 2'(s) && slot_v[s]) begin
                    grant_valid = 1'b1;
                    grant_idx   = 2'(s);
                    grant_a     = slot_a[s];
                    grant_d     = slot_d[s];
                end
            end
        end
        granted = '0;
        if (grant_valid) begin
            granted[grant_idx] = 1'b1;
        end
        rr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end

    // Ready: slot free (or draining this cycle) and no older write to the same register.
    // Address 0 is a discard, so it never conflicts with anything.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = 0; j < NSRC; j++) begin
                if (req_a[i] != 5'd0 && j != i && slot_v[j] && !granted[j]
                    && slot_a[j] == req_a[i]) begin
                    conflict[i] = 1'b1;
                end
                if (req_a[i] != 5'd0 && j < i && req_valid[j] && req_a[j] == req_a[i]) begin
                    conflict[i] = 1'b1;
                end
            end
        end
        req_ready = {NSRC{rst_n}} & (~slot_v | granted) & ~conflict;
        accept    = req_valid & req_ready;
    end

    // Slots, round-robin pointer and the registered write stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_v <= '0;
            for (int i = 0; i < NSRC; i++) begin
                slot_a[i] <= 5'd0;
                slot_d[i] <= 32'd0;
            end
            rr    <= 2'd0;
            rf_wr <= 1'b0;
            rf_a3 <= 5'd0;
            rf_wd <= 32'd0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (accept[i] && req_a[i] != 5'd0) begin
                    slot_v[i] <= 1'b1;
                    slot_a[i] <= req_a[i];
                    slot_d[i] <= req_d[i];
                end else if (granted[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
            rf_wr <= grant_valid;
            if (grant_valid) begin
                rf_a3 <= grant_a;
                rf_wd <= grant_d;
                rr    <= rr_next;
            end
        end
    end

    // Pending-write mask for the issue stage's hazard check.
    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (slot_v[i]) begin
                pending = pending | (32'd1 << slot_a[i]);
            end
        end
        if (rf_wr) begin
            pending = pending | (32'd1 << rf_a3);
        end
        pending[0] = 1'b0;
    end

`ifdef RF_WB_BYPASS_EN
    logic [4:0]  byp_addr [2];
    logic        byp_hit  [2];
    logic [31:0] byp_dat  [2];

    assign byp_addr[0] = byp_a1;
    assign byp_addr[1] = byp_a2;
    assign byp_hit1    = byp_hit[0];
    assign byp_hit2    = byp_hit[1];
    assign byp_d1      = byp_dat[0];
    assign byp_d2      = byp_dat[1];

    // Bypass lookup; a slot holds a newer value than the output stage, so it wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            byp_hit[p] = 1'b0;
            byp_dat[p] = 32'd0;
            if (byp_addr[p] != 5'd0) begin
                if (rf_wr && rf_a3 == byp_addr[p]) begin
                    byp_hit[p] = 1'b1;
                    byp_dat[p] = rf_wd;
                end
                for (int i = 0; i < NSRC; i++) begin
                    if (slot_v[i] && slot_a[i] == byp_addr[p]) begin
                        byp_hit[p] = 1'b1;
                        byp_dat[p] = slot_d[i];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: behavioural slot/round-robin model, directed scenarios
// with literal expectations, then randomized traffic checked every cycle.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] pending;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  byp_a1, byp_a2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_d1, byp_d2;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
`ifdef RF_WB_BYPASS_EN
        .byp_a1(byp_a1), .byp_a2(byp_a2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_d1(byp_d1), .byp_d2(byp_d2),
`endif
        .pending(pending)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          mv [3];
    logic [4:0]  ma [3];
    logic [31:0] md [3];
    int          mrr;
    bit          mwr;
    logic [4:0]  ma3;
    logic [31:0] mwd;
    int          mg;
    bit          mrdy [3];

    // Register file image, committed on the falling edge like the real array
    logic [31:0] regs [32];
    always @(negedge clk) if (rf_wr) regs[rf_a3] <= rf_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] a_of(input int i);
        return req_addr[5*i +: 5];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin mv[i] = 0; ma[i] = 0; md[i] = 0; end
        mrr = 0; mwr = 0; ma3 = 0; mwd = 0;
    endtask

    // Who is granted and who is ready this cycle, from the current inputs
    task automatic model_eval();
        mg = -1;
        for (int k = 0; k < 3; k++)
            if (mg < 0 && mv[(mrr + k) % 3]) mg = (mrr + k) % 3;
        for (int i = 0; i < 3; i++) begin
            bit conf = 0;
            if (a_of(i) != 0) begin
                for (int j = 0; j < 3; j++) begin
                    if (j != i && mv[j] && mg != j && ma[j] == a_of(i)) conf = 1;
                    if (j < i && req_valid[j] && a_of(j) == a_of(i)) conf = 1;
                end
            end
            mrdy[i] = rst_n && (!mv[i] || mg == i) && !conf;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mg >= 0) begin
                mwr = 1; ma3 = ma[mg]; mwd = md[mg]; mv[mg] = 0; mrr = (mg + 1) % 3;
            end else begin
                mwr = 0;
            end
            for (int i = 0; i < 3; i++)
                if (req_valid[i] && mrdy[i] && a_of(i) != 0) begin
                    mv[i] = 1; ma[i] = a_of(i); md[i] = req_data[32*i +: 32];
                end
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = 0;
        for (int i = 0; i < 3; i++) if (mv[i]) p[ma[i]] = 1'b1;
        if (mwr) p[ma3] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

`ifdef RF_WB_BYPASS_EN
    task automatic check_byp(input string name, input logic [4:0] a,
                             input logic hit, input logic [31:0] d);
        logic        eh = 0;
        logic [31:0] ed = 0;
        if (a != 0) begin
            if (mwr && ma3 == a) begin eh = 1; ed = mwd; end
            for (int i = 0; i < 3; i++) if (mv[i] && ma[i] == a) begin eh = 1; ed = md[i]; end
        end
        chk({name, "_hit"}, 32'(hit), 32'(eh));
        chk({name, "_data"}, d, ed);
    endtask
`endif

    // Apply inputs for the cycle and check the combinational outputs against the model
    task automatic drive(input logic r, input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        rst_n = r; req_valid = v;
        req_addr = {a2, a1, a0};
        req_data = {d2, d1, d0};
        #1;
        model_eval();
        chk("req_ready", 32'(req_ready), 32'({mrdy[2], mrdy[1], mrdy[0]}));
`ifdef RF_WB_BYPASS_EN
        check_byp("byp1", byp_a1, byp_hit1, byp_d1);
        check_byp("byp2", byp_a2, byp_hit2, byp_d2);
`endif
    endtask

    // Clock edge, then check registered outputs against the model
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("rf_wr", 32'(rf_wr), 32'(mwr));
        chk("rf_a3", 32'(rf_a3), 32'(ma3));
        chk("rf_wd", rf_wd, mwd);
        chk("pending", pending, model_pending());
    endtask

    task automatic idle();
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic do_reset();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        rst_n = 0; req_valid = 0; req_addr = 0; req_data = 0;
`ifdef RF_WB_BYPASS_EN
        byp_a1 = 0; byp_a2 = 0;
`endif
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("reset_rf_wr", 32'(rf_wr), 32'd0);
        chk("reset_pending", pending, 32'd0);

        // Single write, two-edge latency
        drive(1, 3'b010, 0, 5, 0, 0, 32'h12345678, 0);
        tick();
        chk("lat_e0_pending", pending, 32'h0000_0020);
        chk("lat_e0_rf_wr", 32'(rf_wr), 32'd0);
        idle();
        chk("lat_e1_rf_wr", 32'(rf_wr), 32'd1);
        chk("lat_e1_rf_a3", 32'(rf_a3), 32'd5);
        chk("lat_e1_rf_wd", rf_wd, 32'h12345678);
        chk("lat_e1_pending", pending, 32'h0000_0020);
        idle();
        chk("lat_e2_rf_wr", 32'(rf_wr), 32'd0);
        chk("lat_e2_pending", pending, 32'd0);

        // Round robin over three full slots
        do_reset();
        drive(1, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33);
        tick();
        chk("rr_pending", pending, 32'h0000_000E);
        idle(); chk("rr_first", 32'(rf_a3), 32'd1);
        idle(); chk("rr_second", 32'(rf_a3), 32'd2);
        idle(); chk("rr_third", 32'(rf_a3), 32'd3);
        drive(1, 3'b111, 4, 5, 6, 32'h44, 32'h55, 32'h66);
        tick();
        idle(); chk("rr_wrap", 32'(rf_a3), 32'd4);
        idle(); idle(); idle();

        // Same-register requests: lower index wins, order preserved
        do_reset();
        drive(1, 3'b101, 7, 0, 7, 32'hAAAA0000, 0, 32'hBBBB2222);
        chk("order_ready_first", 32'(req_ready), 32'b011);
        tick();
        drive(1, 3'b100, 0, 0, 7, 0, 0, 32'hBBBB2222);
        chk("order_ready_src2", 32'(req_ready[2]), 32'd1);
        tick();
        idle(); idle(); idle();
        chk("order_regfile_r7", regs[7], 32'hBBBB2222);

        // Writes to r0 are swallowed
        drive(1, 3'b001, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
        chk("r0_ready", 32'(req_ready[0]), 32'd1);
        tick();
        chk("r0_pending", pending, 32'd0);
        idle();
        chk("r0_rf_wr", 32'(rf_wr), 32'd0);

        // Reset while slots are occupied
        drive(1, 3'b011, 10, 11, 0, 32'hC0, 32'hC1, 0);
        tick();
        drive(0, 3'b011, 12, 13, 0, 32'hD0, 32'hD1, 0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst_rf_wr", 32'(rf_wr), 32'd0);
        chk("rst_pending", pending, 32'd0);
        for (int c = 0; c < 3; c++) begin
            idle();
            chk("rst_no_write", 32'(rf_wr), 32'd0);
        end

`ifdef RF_WB_BYPASS_EN
        // Slot holds newer r9 than the output stage
        do_reset();
        drive(1, 3'b010, 0, 9, 0, 0, 32'hB, 0);
        tick();
        drive(1, 3'b010, 0, 9, 0, 0, 32'hA, 0);
        tick();
        byp_a1 = 9; byp_a2 = 0;
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
        chk("byp_hit1", 32'(byp_hit1), 32'd1);
        chk("byp_d1", byp_d1, 32'hA);
        chk("byp_hit2", 32'(byp_hit2), 32'd0);
        chk("byp_d2", byp_d2, 32'd0);
        tick();
        byp_a1 = 0;
`endif

        // Randomized traffic over a small register set to provoke conflicts
        for (int c = 0; c < 400; c++) begin
            logic r;
            r = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
`ifdef RF_WB_BYPASS_EN
            byp_a1 = 5'($urandom_range(0, 5));
            byp_a2 = 5'($urandom_range(0, 5));
`endif
            drive(r, 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  $urandom, $urandom, $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
